// File: rtl/led_channel_blinker.sv
// Multi-channel LED driver: a shared prescaler tick advances per-channel OFF/ON/BLINK/PWM
// engines, each reconfigured at runtime through a single-cycle write port.
module led_channel_blinker #(
  parameter  int CHANNELS = 4,
  parameter  int CNT_W    = 32,
  parameter  int PRESCALE = 100000,
  parameter  int DUTY_W   = 8,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK_IN,
  input  logic                RST,
  input  logic                WR_EN,
  input  logic [CH_W-1:0]     WR_CH,
  input  logic [1:0]          WR_MODE,
  input  logic [CNT_W-1:0]    WR_PERIOD,
  input  logic [DUTY_W-1:0]   WR_DUTY,
  output logic [CHANNELS-1:0] LED,
  output logic                TICK
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_t;

  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre;
  logic             tick_now;
  logic             wr_valid;

  mode_t              mode_q   [CHANNELS];
  mode_t              mode_d   [CHANNELS];
  logic [CNT_W-1:0]   period_q [CHANNELS];
  logic [CNT_W-1:0]   period_d [CHANNELS];
  logic [DUTY_W-1:0]  duty_q   [CHANNELS];
  logic [DUTY_W-1:0]  duty_d   [CHANNELS];
  logic [CNT_W-1:0]   bcnt_q   [CHANNELS];
  logic [CNT_W-1:0]   bcnt_d   [CHANNELS];
  logic [DUTY_W-1:0]  pcnt_q   [CHANNELS];
  logic [DUTY_W-1:0]  pcnt_d   [CHANNELS];
  logic [CHANNELS-1:0] led_d;

  // Last count of a BLINK half-period; a programmed period of 0 behaves as 1.
  function automatic logic [CNT_W-1:0] blink_last(input logic [CNT_W-1:0] period);
    return (period == '0) ? '0 : period - 1'b1;
  endfunction

  assign tick_now = (pre == PRE_LAST);
  assign wr_valid = WR_EN && ({1'b0, WR_CH} < (CH_W + 1)'(CHANNELS));

  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      pre  <= '0;
      TICK <= 1'b0;
    end else begin
      TICK <= tick_now;
      pre  <= tick_now ? '0 : pre + 1'b1;
    end
  end

  // A write to a channel overrides that channel's tick update on the same edge.
  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    bcnt_d   = bcnt_q;
    pcnt_d   = pcnt_q;
    led_d    = LED;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_valid && (WR_CH == CH_W'(i))) begin
        mode_d[i]   = mode_t'(WR_MODE);
        period_d[i] = WR_PERIOD;
        duty_d[i]   = WR_DUTY;
        bcnt_d[i]   = '0;
        pcnt_d[i]   = '0;
        case (mode_t'(WR_MODE))
          MODE_OFF:   led_d[i] = 1'b0;
          MODE_ON:    led_d[i] = 1'b1;
          MODE_BLINK: led_d[i] = 1'b1;
          MODE_PWM:   led_d[i] = (WR_DUTY != '0);
          default:    led_d[i] = 1'b0;
        endcase
      end else if (tick_now) begin
        case (mode_q[i])
          MODE_OFF: led_d[i] = 1'b0;
          MODE_ON:  led_d[i] = 1'b1;
          MODE_BLINK: begin
            if (bcnt_q[i] == blink_last(period_q[i])) begin
              led_d[i]  = ~LED[i];
              bcnt_d[i] = '0;
            end else begin
              bcnt_d[i] = bcnt_q[i] + 1'b1;
            end
          end
          MODE_PWM: begin
            pcnt_d[i] = pcnt_q[i] + 1'b1;
            led_d[i]  = (pcnt_d[i] < duty_q[i]);
          end
          default: led_d[i] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= '0;
        duty_q[i]   <= '0;
        bcnt_q[i]   <= '0;
        pcnt_q[i]   <= '0;
      end
      LED <= '0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      bcnt_q   <= bcnt_d;
      pcnt_q   <= pcnt_d;
      LED      <= led_d;
    end
  end

endmodule

// File: tb/tb_led_channel_blinker.sv
// Directed bench for led_channel_blinker: a 4-channel instance driven from a vector table,
// plus small instances for invalid-channel writes and the PRESCALE=1 corner.
module tb_led_channel_blinker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: 4 channels, tick every 4 cycles, 8-bit PWM
  logic        a_wr_en = 1'b0;
  logic [1:0]  a_ch = '0;
  logic [1:0]  a_mode = '0;
  logic [31:0] a_period = '0;
  logic [7:0]  a_duty = '0;
  logic [3:0]  a_led;
  logic        a_tick;

  // Instance B: 3 channels, so channel index 3 is out of range
  logic        b_wr_en = 1'b0;
  logic [1:0]  b_ch = '0;
  logic [1:0]  b_mode = '0;
  logic [31:0] b_period = '0;
  logic [7:0]  b_duty = '0;
  logic [2:0]  b_led;
  logic        b_tick;

  // Instance C: single channel, tick every cycle, 2-bit PWM
  logic        c_wr_en = 1'b0;
  logic [0:0]  c_ch = '0;
  logic [1:0]  c_mode = '0;
  logic [31:0] c_period = '0;
  logic [1:0]  c_duty = '0;
  logic [0:0]  c_led;
  logic        c_tick;

  led_channel_blinker #(.CHANNELS(4), .CNT_W(32), .PRESCALE(4), .DUTY_W(8)) dut_a (
    .CLK_IN(clk), .RST(rst), .WR_EN(a_wr_en), .WR_CH(a_ch), .WR_MODE(a_mode),
    .WR_PERIOD(a_period), .WR_DUTY(a_duty), .LED(a_led), .TICK(a_tick)
  );

  led_channel_blinker #(.CHANNELS(3), .CNT_W(32), .PRESCALE(4), .DUTY_W(8)) dut_b (
    .CLK_IN(clk), .RST(rst), .WR_EN(b_wr_en), .WR_CH(b_ch), .WR_MODE(b_mode),
    .WR_PERIOD(b_period), .WR_DUTY(b_duty), .LED(b_led), .TICK(b_tick)
  );

  led_channel_blinker #(.CHANNELS(1), .CNT_W(32), .PRESCALE(1), .DUTY_W(2)) dut_c (
    .CLK_IN(clk), .RST(rst), .WR_EN(c_wr_en), .WR_CH(c_ch), .WR_MODE(c_mode),
    .WR_PERIOD(c_period), .WR_DUTY(c_duty), .LED(c_led), .TICK(c_tick)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  ch;
    logic [1:0]  mode;
    logic [31:0] period;
    logic [7:0]  duty;
    int          adv;
    logic [3:0]  led;
    logic        tick;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Optional write lands on the first edge; total of v.adv edges before sampling.
  task automatic apply_stimulus(input vec_t v);
    if (v.wr) begin
      a_wr_en  = 1'b1;
      a_ch     = v.ch;
      a_mode   = v.mode;
      a_period = v.period;
      a_duty   = v.duty;
    end
    step(1);
    a_wr_en = 1'b0;
    if (v.adv > 1) step(v.adv - 1);
  endtask

  initial begin
    bit pat [4];
    pat = '{1'b1, 1'b1, 1'b1, 1'b0};

    // Edge numbers after reset release; ticks land on multiples of 4.
    vecs[0]  = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   3,   4'b0000, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   1,   4'b0000, 1'b1};
    vecs[2]  = '{1'b1, 2'd1, 2'b10, 32'd3, 8'd0,   1,   4'b0010, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   10,  4'b0010, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   1,   4'b0000, 1'b1};
    vecs[5]  = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   11,  4'b0000, 1'b0};
    vecs[6]  = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   1,   4'b0010, 1'b1};
    vecs[7]  = '{1'b1, 2'd2, 2'b11, 32'd0, 8'd64,  1,   4'b0110, 1'b0};
    vecs[8]  = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   254, 4'b0100, 1'b0};
    vecs[9]  = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   1,   4'b0000, 1'b1};
    vecs[10] = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   767, 4'b0000, 1'b0};
    vecs[11] = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   1,   4'b0100, 1'b1};
    vecs[12] = '{1'b1, 2'd2, 2'b11, 32'd0, 8'd0,   1,   4'b0000, 1'b0};
    vecs[13] = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   40,  4'b0010, 1'b0};
    vecs[14] = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   2,   4'b0010, 1'b0};
    vecs[15] = '{1'b1, 2'd3, 2'b10, 32'd0, 8'd0,   1,   4'b1000, 1'b1};
    vecs[16] = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   3,   4'b1000, 1'b0};
    vecs[17] = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   1,   4'b0000, 1'b1};
    vecs[18] = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   4,   4'b1000, 1'b1};
    vecs[19] = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   15,  4'b0010, 1'b0};
    vecs[20] = '{1'b1, 2'd1, 2'b10, 32'd3, 8'd0,   1,   4'b1010, 1'b1};
    vecs[21] = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   11,  4'b1010, 1'b0};
    vecs[22] = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   1,   4'b0000, 1'b1};
    vecs[23] = '{1'b0, 2'd0, 2'b00, 32'd0, 8'd0,   4,   4'b1000, 1'b1};

    $display("[TB] start");
    step(2);
    check_output("reset_a_led", 32'(a_led), 32'h0);
    check_output("reset_a_tick", 32'(a_tick), 32'h0);
    check_output("reset_b_led", 32'(b_led), 32'h0);
    check_output("reset_c_tick", 32'(c_tick), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d_led", i), 32'(a_led), 32'(vecs[i].led));
      check_output($sformatf("vec%0d_tick", i), 32'(a_tick), 32'(vecs[i].tick));
    end

    // Asynchronous reset between edges while LED[3] and TICK are high
    #3;
    rst = 1'b1;
    #1;
    check_output("async_rst_led", 32'(a_led), 32'h0);
    check_output("async_rst_tick", 32'(a_tick), 32'h0);
    step(2);
    rst = 1'b0;
    step(1);
    check_output("post_rst_e1_tick", 32'(a_tick), 32'h0);
    check_output("c_tick_e1", 32'(c_tick), 32'h1);
    step(2);
    check_output("post_rst_e3_tick", 32'(a_tick), 32'h0);
    check_output("post_rst_e3_led", 32'(a_led), 32'h0);
    step(1);
    check_output("post_rst_e4_tick", 32'(a_tick), 32'h1);
    check_output("post_rst_e4_led", 32'(a_led), 32'h0);
    step(3);
    check_output("post_rst_e7_tick", 32'(a_tick), 32'h0);
    step(1);
    check_output("post_rst_e8_tick", 32'(a_tick), 32'h1);
    check_output("post_rst_e8_led", 32'(a_led), 32'h0);

    // Out-of-range channel write on the 3-channel instance, then ch0 ON/OFF
    b_wr_en = 1'b1;
    b_ch    = 2'd3;
    b_mode  = 2'b01;
    step(1);
    b_wr_en = 1'b0;
    check_output("b_invalid_ch", 32'(b_led), 32'h0);
    step(4);
    check_output("b_invalid_ch_later", 32'(b_led), 32'h0);
    b_wr_en = 1'b1;
    b_ch    = 2'd0;
    b_mode  = 2'b01;
    step(1);
    check_output("b_ch0_on", 32'(b_led), 32'h1);
    b_mode  = 2'b00;
    step(1);
    b_wr_en = 1'b0;
    check_output("b_ch0_off", 32'(b_led), 32'h0);

    // PRESCALE=1 PWM with duty 3 of a 4-tick frame
    c_wr_en = 1'b1;
    c_ch    = 1'b0;
    c_mode  = 2'b11;
    c_duty  = 2'd3;
    step(1);
    c_wr_en = 1'b0;
    check_output("c_pwm_k0", 32'(c_led), 32'(pat[0]));
    for (int k = 1; k < 8; k++) begin
      step(1);
      check_output($sformatf("c_pwm_k%0d", k), 32'(c_led), 32'(pat[k % 4]));
      check_output($sformatf("c_tick_k%0d", k), 32'(c_tick), 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
